// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - FSM state encodings (IDLE/START/DATA/STOP/PARITY).
//   - Default frame parameters (DBIT/SB_TICK/S), so both ends of a link
//     are configured the same way.
//   - clog2 helper for sizing counters from parameters.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int S_DEF       = 16;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk    : destination clock
//   reset  : asynchronous, active-low reset
//   d      : asynchronous input
//   q      : synchronized output (2 clk latency)
// RESET_VAL sets the value both flops take in reset, so an idle-high line
// does not look like an edge when reset is released.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, DBIT data bits LSB first, one stop bit.
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   s_tick       : one-clk oversample strobe, S per bit period
//   rx           : raw serial line, idle high, asynchronous to clk
//   dout         : last received data word (held until next frame)
//   rx_done_tick : one-clk pulse when a frame completes
//   frame_err    : stop-bit sample of the last frame was 0
//   parity_err   : parity check of the last frame failed
//                  (only when UART_RX_PARITY_EN is defined)
//   state_dbg    : current FSM state (uart_pkg encodings)
// Optional feature macro: UART_RX_PARITY_EN inserts a PARITY state between
// DATA and STOP and adds parameter PARITY_ODD and output parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int S       = S_DEF
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic [2:0]      state_dbg
);

    localparam int MAXT   = (S > SB_TICK) ? S : SB_TICK;
    localparam int SW     = (clog2(MAXT) < 1) ? 1 : clog2(MAXT);
    localparam int NW     = (clog2(DBIT) < 1) ? 1 : clog2(DBIT);

    localparam logic [SW-1:0] HALF_LAST = SW'(S / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(S - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    logic [2:0]      state_q,  state_d;
    logic [SW-1:0]   s_q,      s_d;
    logic [NW-1:0]   n_q,      n_d;
    logic [DBIT-1:0] shift_q,  shift_d;
    logic [DBIT-1:0] dout_q,   dout_d;
    logic            done_q,   done_d;
    logic            ferr_q,   ferr_d;
    logic            armed_q,  armed_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q,    par_d;
    logic            perr_q,   perr_d;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        armed_d = armed_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                // Start detection is level based and runs every clk; after a
                // frame that ended low (break), wait for the line to go high.
                if (!armed_q) begin
                    if (rx_s) armed_d = 1'b1;
                end else if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == HALF_LAST) begin
                        if (!rx_s) begin
                            // Mid start bit: from here every S ticks is mid-bit.
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        dout_d  = shift_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        s_d     = '0;
                        state_d = IDLE;
                        if (!rx_s) armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        dout         = dout_q;
        rx_done_tick = done_q;
        frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
        parity_err   = perr_q;
`endif
        state_dbg    = state_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (S=16, DBIT=8,
// s_tick every 4 clk, so one bit period is 64 clk).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] tick_cnt = 2'd0;
    logic       s_tick;
    always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
    assign s_tick = (tick_cnt == 2'd3);

    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic [2:0] state_dbg;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16),
        .S       (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .state_dbg    (state_dbg)
    );

    // Scoreboard: {frame_err, dout}
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         done_cnt = 0;
    int         check_cnt = 0;
    int         pass_cnt = 0;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            got_q.push_back({frame_err, dout});
            done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check({tag, "_frame"}, {23'd0, got_q.pop_front()}, {23'd0, exp_q.pop_front()});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Driver: start bit, 8 data bits LSB first, [parity], stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        wait_clk(BIT_CLK);
`else
        if (par_bit) begin end
`endif
        rx = stop_bit;
        wait_clk(BIT_CLK);
    endtask

    initial begin
        logic [7:0] d81;
        int         cnt0;
        d81 = 8'h81;

        // Reset state
        reset = 1'b0;
        rx    = 1'b1;
        wait_clk(5);
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        check("rst_done", {31'd0, rx_done_tick}, 32'h0);
        check("rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
        reset = 1'b1;
        wait_clk(BIT_CLK);

        // Good frame 0xA5
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_clk(BIT_CLK);
        check_frames("a5");

        // Glitch: 5 s_ticks low
        cnt0 = done_cnt;
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(200);
        check("glitch_pulses", done_cnt - cnt0, 32'd0);
        check("glitch_state", {29'd0, state_dbg}, {29'd0, IDLE});
        check("glitch_dout", {24'd0, dout}, 32'hA5);

        // Framing error followed by a held break
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_clk(3 * 10 * BIT_CLK);
        check_frames("break");
        rx = 1'b1;
        wait_clk(BIT_CLK);
        exp_q.push_back({1'b0, 8'h00});
        send_frame(8'h00, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        check_frames("after_break");

        // Back-to-back frames
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        check_frames("b2b");

        // Reset in the middle of data bit 4 of 0x81
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = d81[i];
            wait_clk(BIT_CLK);
        end
        rx = d81[4];
        wait_clk(BIT_CLK / 2);
        reset = 1'b0;
        rx    = 1'b1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(2 * BIT_CLK);
        check_frames("abort");
        check("abort_dout", {24'd0, dout}, 32'h0);
        check("abort_ferr", {31'd0, frame_err}, 32'h0);
        exp_q.push_back({1'b0, 8'h42});
        send_frame(8'h42, 1'b1, ^8'h42);
        wait_clk(BIT_CLK);
        check_frames("x42");

`ifdef UART_RX_PARITY_EN
        // Even parity (PARITY_ODD=0): 0x07 has three ones
        exp_q.push_back({1'b0, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check_frames("par_ok");
        check("par_ok_err", {31'd0, parity_err}, 32'h0);
        exp_q.push_back({1'b0, 8'h07});
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        check_frames("par_bad");
        check("par_bad_err", {31'd0, parity_err}, 32'h1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: oversampled serial-to-parallel converter for 8N1-style frames, LSB first.
- Pairs with the transmitter on the same link.
- Shares the baud-tick generator's s_tick (S ticks per bit) and the DBIT/SB_TICK/S parameter set, so the two ends are configured identically.
- Sits between the pad-side rx line and the banner/command logic, which consumes dout on rx_done_tick.

Parameters:
- DBIT, 8, data bits per frame.
- SB_TICK, 16, s_ticks spent in the stop bit (16 = 1 stop bit at S=16).
- S, 16, s_ticks per bit; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- s_tick  input  1  one-clk oversample strobe, S per bit period.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-clk pulse when a frame completes.
- frame_err  output  1  stop-bit sample of the last frame was 0.

Behaviour:
- Reset (reset=0, async): both sync flops = 1, state = IDLE, s_reg = 0, n = 0, shift reg = 0, dout = 0, rx_done_tick = 0, frame_err = 0, armed = 1.
- Input synchronizer: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only, adding 2 clk of latency.
- IDLE:
  - rx_done_tick = 0.
  - If armed=0, wait for rx_s=1, then set armed=1.
  - If armed=1 and rx_s=0: go to START, s_reg = 0. This check is level-based on every clk; s_tick is not required.
- START (on s_tick only):
  - If s_reg == S/2-1 and rx_s = 0: go to DATA, s_reg = 0, n = 0 (aligned to mid-bit).
  - If s_reg == S/2-1 and rx_s = 1: false start, return to IDLE, no output change.
  - Otherwise s_reg++.
- DATA (on s_tick only):
  - If s_reg == S-1: s_reg = 0, shift reg = {rx_s, shift[DBIT-1:1]}.
  - If n == DBIT-1, go to STOP; else n++.
  - Otherwise s_reg++.
- STOP (on s_tick only):
  - If s_reg == SB_TICK-1: dout = shift reg, frame_err = ~rx_s, rx_done_tick = 1 for exactly one clk, s_reg = 0, go to IDLE.
  - If rx_s = 0, also set armed = 0. This blocks a held-low break from producing back-to-back frames.
  - Otherwise s_reg++.
- Counter widths: s_reg is sized for max(S, SB_TICK)-1; n is sized for DBIT-1. There is no wrap in normal operation.
- Output hold: dout and frame_err hold their values until the next frame completes. frame_err is valid in the same clk as rx_done_tick. A frame with an error still updates dout.
- Latency: rx_done_tick fires S/2 + DBIT·S + SB_TICK s_ticks after the first rx_s=0, plus 2 clk for synchronization.
- Back-to-back frames: STOP returns to IDLE at mid-stop-bit, so a start edge immediately after the stop bit is caught.
- Glitch filter: rx low for fewer than S/2 ticks is treated as a false start.
- s_tick and rx changing in the same clk: the FSM uses the already-registered rx_s, so the result is deterministic.
- Reset mid-frame: the partial frame is discarded; no done pulse and no error is reported.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0) is added, plus output parity_err (1 bit, reset 0).
  - A PARITY state is inserted between DATA and STOP; it samples one bit at s_reg == S-1.
  - parity_err = (XOR of data bits ^ parity bit) != PARITY_ODD. It updates together with dout on rx_done_tick.
- When undefined: no PARITY state, no parity_err port, frames are DBIT+2 bits.

Decomposition:
- Shared package/header uart_pkg holds:
  - state localparams IDLE/START/DATA/STOP/PARITY, used by the transmitter too;
  - default DBIT/SB_TICK/S;
  - the shared clog2 helper function.
- One natural sub-module: sync_2ff, a parameterized-reset-value 2-flop synchronizer, reusable for other async inputs.

Test Plan:
- Setup: S=16, DBIT=8, s_tick every 4 clk, rx driven by a bench TX model.
- Send 0xA5 with a valid stop bit -> one rx_done_tick, dout=0xA5, frame_err=0.
- Drive rx low for 5 s_ticks then high -> no rx_done_tick, FSM back in IDLE, dout unchanged.
- Send 0x3C with stop bit 0, then hold rx low for 3 frame times -> exactly one done pulse, dout=0x3C, frame_err=1. No further pulses until rx returns high and a new 0x00 frame is sent (then frame_err=0).
- Send 0x00 and 0xFF back-to-back with no idle gap -> two done pulses in order, dout=0x00 then 0xFF.
- Assert reset during data bit 4 of 0x81, release, then send 0x42 -> no pulse for the aborted frame, dout=0x42.
- With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x07 with parity 1 -> parity_err=0; send 0x07 with parity 0 -> parity_err=1.
